jtag_word_shifter: RTL

- Consumer-side partner of the team's single-clock show-ahead FIFO.
- Pops one word from a command FIFO and shifts it LSB-first onto TDI using a divided TCK.
- Captures TDO bit-for-bit into a word and pushes that word into a response FIFO.
- Covers Shift-DR/Shift-IR data only. TAP state navigation (TMS) is handled elsewhere.

---
 rtl/jtag_word_shifter_pkg.sv | 23 ++
 rtl/jtag_word_shifter_if.sv | 33 +++
 rtl/jtag_word_shifter_tck_gen.sv | 44 ++++
 rtl/jtag_word_shifter.sv | 113 +++++++++++
 4 files changed

// File: rtl/jtag_word_shifter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : jtag_pkg                                                         |
// | Desc     : Shared state type and constants for the JTAG word shifter.       |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
package jtag_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        STORE = 2'd2
    } jtag_state_t;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_CLK_DIV    = 2;

    function automatic int div_cnt_width(input int clk_div);
        return (clk_div > 1) ? $clog2(clk_div) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jtag_word_shifter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : jtag_word_shifter_if                                             |
// | Desc     : FIFO handshake and JTAG pin bundle for the word shifter.         |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
interface jtag_word_shifter_if
    import jtag_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic [DATA_WIDTH-1:0] in_rdata;
    logic                  in_empty;
    logic                  in_rd;
    logic [DATA_WIDTH-1:0] out_wdata;
    logic                  out_wr;
    logic                  out_full;
    logic                  tck;
    logic                  tdi;
    logic                  tdo;
    logic                  busy;

    modport master (
        input  in_rdata, in_empty, out_full, tdo,
        output in_rd, out_wdata, out_wr, tck, tdi, busy
    );

    modport slave (
        output in_rdata, in_empty, out_full, tdo,
        input  in_rd, out_wdata, out_wr, tck, tdi, busy
    );
endinterface
`default_nettype wire

// File: rtl/jtag_word_shifter_tck_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : jtag_tck_gen                                                     |
// | Desc     : TCK divider with single-cycle rise/fall strobes.                 |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module jtag_tck_gen
    import jtag_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tck,
    output logic rise_pulse,
    output logic fall_pulse
);
    localparam int               c_DIV_W    = div_cnt_width(CLK_DIV);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);

    logic [c_DIV_W-1:0] r_div;
    logic               r_tck;
    logic               w_terminal;

    // Strobes mark the clk edge on which tck is about to toggle.
    assign w_terminal = en && (r_div == c_DIV_LAST);
    assign rise_pulse = w_terminal && !r_tck;
    assign fall_pulse = w_terminal && r_tck;
    assign tck        = r_tck;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_div <= '0;
            r_tck <= 1'b0;
        end else if (w_terminal) begin
            r_div <= '0;
            r_tck <= ~r_tck;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/jtag_word_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : jtag_word_shifter                                                |
// | Desc     : Pops a command word, shifts it LSB-first on TDI, pushes TDO word.|
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module jtag_word_shifter
    import jtag_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int CLK_DIV    = DEFAULT_CLK_DIV
) (
    input  logic                clk,
    input  logic                rst,
    jtag_word_shifter_if.master bus
);
    localparam int                 c_BIT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(DATA_WIDTH - 1);

    jtag_state_t           r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_capture;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [c_BIT_W-1:0]    r_bitcnt;
    logic                  r_tdi;
    logic                  r_wr;
    logic                  r_busy;

    logic                  w_pop;
    logic                  w_tck_en;
    logic                  w_tck;
    logic                  w_rise;
    logic                  w_fall;
    logic [DATA_WIDTH-1:0] w_shift_next;

    // Pop only with guaranteed room downstream; this block is the sole writer.
    assign w_pop        = !rst && (r_state == IDLE) && !bus.in_empty && !bus.out_full;
    assign w_tck_en     = (r_state == SHIFT);
    assign w_shift_next = r_shift >> 1;

    jtag_tck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tck_gen (
        .clk        (clk),
        .rst        (rst),
        .en         (w_tck_en),
        .tck        (w_tck),
        .rise_pulse (w_rise),
        .fall_pulse (w_fall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_capture <= '0;
            r_wdata   <= '0;
            r_bitcnt  <= '0;
            r_tdi     <= 1'b0;
            r_wr      <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_wr <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tdi <= 1'b0;
                    if (w_pop) begin
                        r_shift   <= bus.in_rdata;
                        r_capture <= '0;
                        r_bitcnt  <= '0;
                        r_tdi     <= bus.in_rdata[0];
                        r_busy    <= 1'b1;
                        r_state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_rise) begin
                        r_capture <= {bus.tdo, r_capture[DATA_WIDTH-1:1]};
                    end
                    if (w_fall) begin
                        r_shift  <= w_shift_next;
                        r_bitcnt <= r_bitcnt + 1'b1;
                        if (r_bitcnt == c_BIT_LAST) begin
                            // Last bit done: tdi keeps the final bit through STORE.
                            r_wdata <= r_capture;
                            r_wr    <= 1'b1;
                            r_state <= STORE;
                        end else begin
                            r_tdi <= w_shift_next[0];
                        end
                    end
                end
                STORE: begin
                    r_tdi   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_rd     = w_pop;
    assign bus.out_wdata = r_wdata;
    assign bus.out_wr    = r_wr;
    assign bus.tck       = w_tck;
    assign bus.tdi       = r_tdi;
    assign bus.busy      = r_busy;
endmodule
`default_nettype wire
